// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - T-rex runner game sequencer
//
// Purpose: derives the per-frame update strobe and 0..59 animation timer from
// vsync, debounces the jump button, ramps game speed, latches crashes from the
// collision checker, keeps score / high score and restarts the game after a
// game over with a one-cycle game_rst pulse.
//
// Ports:
//   i_clk          single clock
//   i_rst          asynchronous active-low reset, clears all state
//   i_vsync        raw frame sync (asynchronous), rising edge marks a frame
//   i_btn_jump     raw jump button (asynchronous), active-high
//   i_collision    collision level from the collision checker (synchronous)
//   o_update       one-cycle frame strobe
//   o_timer        frame counter 0..59
//   o_speed        game speed
//   o_jump         debounced jump level, forced low in OVER
//   o_crash        latched crash
//   o_game_rst     one-cycle restart pulse to downstream blocks
//   o_score        distance score
//   o_high_score   best score since reset
//   o_playing      high while PLAYING

module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SPEED_INIT      = 6,
  parameter int SPEED_MAX       = 13,
  parameter int ACCEL_FRAMES    = 600,
  parameter int HOLDOFF_FRAMES  = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vsync,
  input  logic        i_btn_jump,
  input  logic        i_collision,
  output logic        o_update,
  output logic [5:0]  o_timer,
  output logic [4:0]  o_speed,
  output logic        o_jump,
  output logic        o_crash,
  output logic        o_game_rst,
  output logic [15:0] o_score,
  output logic [15:0] o_high_score,
  output logic        o_playing
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int HO_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(ACCEL_FRAMES - 1);
  localparam logic [HO_W-1:0] HO_MAX  = HO_W'(HOLDOFF_FRAMES);
  localparam logic [4:0]      SP_INIT = 5'(SPEED_INIT);
  localparam logic [4:0]      SP_MAX  = 5'(SPEED_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_vs_s1, r_vs_s2, r_vs_d, r_tick, r_update;
  logic            r_bt_s1, r_bt_s2;
  logic            r_jump_db, r_jump_db_d;
  logic [DB_W-1:0] r_db_cnt;
  logic [5:0]      r_timer;
  logic [4:0]      r_speed;
  logic [AC_W-1:0] r_accel;
  logic [HO_W-1:0] r_holdoff;
  logic            r_crash;
  logic            r_game_rst;
  logic [15:0]     r_score;
  logic [15:0]     r_high_score;

  logic            w_jump_rise;
  logic            w_restart;
  logic            w_crash_now;
  logic [16:0]     w_score_sum;

  // Synchronizers and frame edge detect. The tick is registered so that a
  // vsync first sampled at edge k yields update in the cycle after edge k+3.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_vs_s1  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_vs_d   <= 1'b0;
      r_tick   <= 1'b0;
      r_update <= 1'b0;
      r_bt_s1  <= 1'b0;
      r_bt_s2  <= 1'b0;
    end else begin
      r_vs_s1  <= i_vsync;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
      r_tick   <= r_vs_s2 & ~r_vs_d;
      r_update <= r_tick;
      r_bt_s1  <= i_btn_jump;
      r_bt_s2  <= r_bt_s1;
    end
  end

  // Debounce: the counter runs only while the synced button disagrees with
  // the debounced level; once it has sat at DB_MAX the level flips.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_db_cnt    <= '0;
      r_jump_db   <= 1'b0;
      r_jump_db_d <= 1'b0;
    end else begin
      r_jump_db_d <= r_jump_db;
      if (r_bt_s2 == r_jump_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_db_cnt  <= '0;
        r_jump_db <= ~r_jump_db;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_jump_rise = r_jump_db & ~r_jump_db_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_crash_now  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_jump_rise) begin
          w_next_state = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        // Collision only counts on a frame strobe.
        if (r_update && i_collision) begin
          w_crash_now  = 1'b1;
          w_next_state = ST_OVER;
        end
      end
      ST_OVER: begin
        if (w_jump_rise && (r_holdoff == HO_MAX)) begin
          w_restart    = 1'b1;
          w_next_state = ST_PLAYING;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_score_sum = {1'b0, r_score} + {12'd0, r_speed};

  // Frame datapath. Restart has priority over a coincident update, so the
  // restart frame is not counted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_timer      <= '0;
      r_speed      <= SP_INIT;
      r_accel      <= '0;
      r_holdoff    <= '0;
      r_crash      <= 1'b0;
      r_game_rst   <= 1'b0;
      r_score      <= '0;
      r_high_score <= '0;
    end else begin
      r_game_rst <= w_restart;

      if (w_restart) begin
        r_timer <= '0;
        r_score <= '0;
        r_speed <= SP_INIT;
        r_accel <= '0;
        r_crash <= 1'b0;
      end else if (r_update) begin
        if (r_state != ST_OVER) begin
          r_timer <= (r_timer == 6'd59) ? 6'd0 : r_timer + 6'd1;
        end
        if (r_state == ST_PLAYING) begin
          r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
          if (r_accel == AC_LAST) begin
            r_accel <= '0;
            if (r_speed < SP_MAX) begin
              r_speed <= r_speed + 5'd1;
            end
          end else begin
            r_accel <= r_accel + 1'b1;
          end
        end
        // High score compares the score before this frame's increment.
        if (w_crash_now) begin
          r_crash <= 1'b1;
          if (r_score > r_high_score) begin
            r_high_score <= r_score;
          end
        end
      end

      if (w_crash_now) begin
        r_holdoff <= '0;
      end else if ((r_state == ST_OVER) && r_update && (r_holdoff != HO_MAX)) begin
        r_holdoff <= r_holdoff + 1'b1;
      end
    end
  end

  assign o_update     = r_update;
  assign o_timer      = r_timer;
  assign o_speed      = r_speed;
  assign o_jump       = r_jump_db & (r_state != ST_OVER);
  assign o_crash      = r_crash;
  assign o_game_rst   = r_game_rst;
  assign o_score      = r_score;
  assign o_high_score = r_high_score;
  assign o_playing    = (r_state == ST_PLAYING);

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl

module tb_game_ctrl;

  localparam int DB    = 4;
  localparam int ACC   = 3;
  localparam int HOLD  = 2;
  localparam int SMAX  = 8;
  localparam int SINIT = 6;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        btn = 1'b0;
  logic        coll = 1'b0;
  logic        o_update, o_jump, o_crash, o_game_rst, o_playing;
  logic [5:0]  o_timer;
  logic [4:0]  o_speed;
  logic [15:0] o_score, o_high_score;

  game_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SPEED_INIT(SINIT),
    .SPEED_MAX(SMAX),
    .ACCEL_FRAMES(ACC),
    .HOLDOFF_FRAMES(HOLD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_vsync(vsync),
    .i_btn_jump(btn),
    .i_collision(coll),
    .o_update(o_update),
    .o_timer(o_timer),
    .o_speed(o_speed),
    .o_jump(o_jump),
    .o_crash(o_crash),
    .o_game_rst(o_game_rst),
    .o_score(o_score),
    .o_high_score(o_high_score),
    .o_playing(o_playing)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int upd_count = 0;
  int grst_count = 0;
  bit cmp_en = 1'b0;
  bit prev_upd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame-count based, sampled input histories.
  int       m_state = M_IDLE;
  bit [7:0] vs_h = '0;
  bit [3:0] bt_h = '0;
  bit       m_update = 1'b0;
  bit       m_db = 1'b0;
  bit       m_db_prev = 1'b0;
  int       m_run = 0;
  int       m_frames = 0;
  int       m_pframes = 0;
  int       m_over = 0;
  int       m_score = 0;
  int       m_high = 0;
  bit       m_crash = 1'b0;
  bit       m_grst = 1'b0;

  function automatic int speed_of(input int p);
    int s;
    s = SINIT + p / ACC;
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; vs_h = '0; bt_h = '0; m_update = 1'b0;
    m_db = 1'b0; m_db_prev = 1'b0; m_run = 0; m_frames = 0; m_pframes = 0;
    m_over = 0; m_score = 0; m_high = 0; m_crash = 1'b0; m_grst = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit upd, rise, old_db;
    int sp, old_score;
    if (!rst_n) begin
      model_reset();
    end else begin
      upd = m_update;
      rise = m_db && !m_db_prev;
      sp = speed_of(m_pframes);
      old_score = m_score;
      m_grst = 1'b0;
      case (m_state)
        M_IDLE: begin
          if (upd) m_frames++;
          if (rise) m_state = M_PLAY;
        end
        M_PLAY: begin
          if (upd) begin
            m_frames++;
            m_score = (old_score + sp > 65535) ? 65535 : old_score + sp;
            m_pframes++;
            if (coll) begin
              m_crash = 1'b1;
              if (old_score > m_high) m_high = old_score;
              m_over = 0;
              m_state = M_OVER;
            end
          end
        end
        default: begin
          if (rise && m_over >= HOLD) begin
            m_grst = 1'b1; m_crash = 1'b0; m_score = 0; m_frames = 0;
            m_pframes = 0; m_state = M_PLAY;
          end else if (upd && m_over < HOLD) begin
            m_over++;
          end
        end
      endcase
      // update appears three edges after the first high vsync sample
      m_update = vs_h[2] && !vs_h[3];
      vs_h = {vs_h[6:0], vsync};
      // level flips after DB+1 consecutive disagreeing synced samples
      old_db = m_db;
      if (bt_h[1] != m_db) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_db = !m_db;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_db_prev = old_db;
      bt_h = {bt_h[2:0], btn};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("update", o_update, m_update);
      if (o_update) chk("update_gap", prev_upd, 0);
      chk("timer", o_timer, m_frames % 60);
      chk("speed", o_speed, speed_of(m_pframes));
      chk("jump", o_jump, m_db && (m_state != M_OVER));
      chk("crash", o_crash, m_crash);
      chk("game_rst", o_game_rst, m_grst);
      chk("score", o_score, m_score);
      chk("high_score", o_high_score, m_high);
      chk("playing", o_playing, m_state == M_PLAY);
      if (o_update) upd_count++;
      if (o_game_rst) grst_count++;
      prev_upd = o_update;
    end
  end

  task automatic frame();
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic set_btn(input bit v, input int n);
    @(negedge clk);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_update"}, o_update, 0);
    chk({tag, "_timer"}, o_timer, 0);
    chk({tag, "_speed"}, o_speed, 6);
    chk({tag, "_jump"}, o_jump, 0);
    chk({tag, "_crash"}, o_crash, 0);
    chk({tag, "_game_rst"}, o_game_rst, 0);
    chk({tag, "_score"}, o_score, 0);
    chk({tag, "_high"}, o_high_score, 0);
    chk({tag, "_playing"}, o_playing, 0);
  endtask

  initial begin
    bit seen;
    int btn_left;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cmp_en = 1'b1;

    upd_count = 0;
    repeat (65) frame();
    chk("idle_updates", upd_count, 65);
    chk("idle_timer", o_timer, 5);
    chk("idle_score", o_score, 0);
    chk("idle_playing", o_playing, 0);

    set_btn(1'b1, 3);
    set_btn(1'b0, 10);
    chk("glitch_jump", o_jump, 0);
    chk("glitch_playing", o_playing, 0);
    set_btn(1'b1, 10);
    chk("press_jump", o_jump, 1);
    chk("press_playing", o_playing, 1);
    set_btn(1'b0, 10);

    repeat (9) frame();
    chk("ramp_speed", o_speed, 8);
    chk("ramp_score", o_score, 63);
    chk("ramp_timer", o_timer, 14);

    @(negedge clk);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    repeat (3) @(negedge clk);
    chk("gap_coll_crash", o_crash, 0);
    chk("gap_coll_playing", o_playing, 1);

    coll = 1'b1;
    frame();
    coll = 1'b0;
    chk("crash_crash", o_crash, 1);
    chk("crash_high", o_high_score, 63);
    chk("crash_score", o_score, 71);
    chk("crash_timer", o_timer, 15);
    chk("crash_playing", o_playing, 0);

    grst_count = 0;
    set_btn(1'b1, 10);
    chk("over_jump_forced", o_jump, 0);
    chk("early_press_grst", grst_count, 0);
    set_btn(1'b0, 10);
    repeat (2) frame();
    chk("over_timer_frozen", o_timer, 15);

    @(negedge clk);
    btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_game_rst) seen = 1'b1;
    end
    chk("grst_seen", seen, 1);
    chk("grst_crash", o_crash, 0);
    chk("grst_playing", o_playing, 1);
    chk("grst_score", o_score, 0);
    chk("grst_speed", o_speed, 6);
    chk("grst_timer", o_timer, 0);
    chk("grst_high", o_high_score, 63);
    repeat (3) @(negedge clk);
    chk("grst_count", grst_count, 1);
    set_btn(1'b0, 10);
    repeat (4) frame();

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;

    btn_left = 0;
    repeat (4000) begin
      @(negedge clk);
      vsync = ($urandom_range(0, 3) == 0);
      coll = ($urandom_range(0, 3) == 0);
      if (btn_left == 0) begin
        btn = !btn;
        btn_left = $urandom_range(1, 15);
      end else begin
        btn_left--;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the T-rex runner. It turns the display's vsync into the per-frame `update` strobe and the 0–59 animation `timer`, and debounces the jump button into the `jump` level. It ramps `speed`, latches crashes reported by the collision checker, keeps score and high score, and issues a one-cycle `game_rst` that restarts the character and obstacle blocks after game over.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples needed before the debounced button level changes.
- `SPEED_INIT`, default 6: `speed` at reset and restart.
- `SPEED_MAX`, default 13: saturation value of `speed`.
- `ACCEL_FRAMES`, default 600: PLAYING frames per +1 speed step.
- `HOLDOFF_FRAMES`, default 30: frames in OVER during which the button is ignored.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous assert, active-low; all state is cleared while low.
- `vsync` in 1: raw frame sync, asynchronous; rising edge marks a frame.
- `btn_jump` in 1: raw jump button, asynchronous, active-high.
- `collision` in 1: level from the collision checker, synchronous.
- `update` out 1: one-cycle frame strobe.
- `timer` out 6: frame counter, 0..59.
- `speed` out 5: game speed.
- `jump` out 1: debounced jump level, gated.
- `crash` out 1: latched crash.
- `game_rst` out 1: one-cycle active-high synchronous restart pulse to downstream blocks.
- `score` out 16: distance score.
- `high_score` out 16: best score since `rst`.
- `playing` out 1: high in PLAYING.

## Operation
- States: IDLE, PLAYING, OVER. Reset state is IDLE.
- Reset values: `update` 0, `timer` 0, `speed` SPEED_INIT, `jump` 0, `crash` 0, `game_rst` 0, `score` 0, `high_score` 0, `playing` 0, debounce level 0, holdoff counter 0, accel counter 0.
- Sync/edge logic:
  - `vsync` and `btn_jump` each pass through a 2-FF synchronizer.
  - `tick` = synced vsync AND NOT its delayed copy.
  - `update` is `tick` registered.
- Debounce:
  - The counter clears whenever the synced button equals `jump_db`.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES, `jump_db` toggles and the counter clears.
  - `jump_rise` is a one-cycle pulse when `jump_db` goes 0→1.
- `jump` = `jump_db` in IDLE and PLAYING; forced 0 in OVER.
- On each cycle with `update` high:
  - `timer` increments, wrapping 59→0, in IDLE and PLAYING; it is frozen in OVER.
  - In PLAYING, `score` adds `speed` and saturates at 0xFFFF.
  - In PLAYING, the accel counter increments. At ACCEL_FRAMES−1 it wraps to 0 and `speed` increments, saturating at SPEED_MAX.
- IDLE→PLAYING on `jump_rise`.
- PLAYING→OVER when `collision` is high in a cycle where `update` is high. On that transition:
  - `crash` is set to 1.
  - If `score` > `high_score`, then `high_score` is set to `score`.
  - The holdoff counter is cleared.
- OVER: the holdoff counter increments on `update` and saturates at HOLDOFF_FRAMES.
- OVER→PLAYING on `jump_rise` with holdoff = HOLDOFF_FRAMES. On that edge:
  - `game_rst` is set to 1 for exactly one cycle.
  - `crash` is set to 0; `score` and `timer` to 0; `speed` to SPEED_INIT; the accel counter to 0.
- Boundary cases:
  - `collision` high without `update`: ignored.
  - `collision` in IDLE or OVER: ignored.
  - `jump_rise` in OVER before holdoff completes: ignored. The button must be released and debounced low, then pressed again.
  - `update` and restart in the same cycle: the restart clears the counters, and that frame is not counted.
  - Crash and `speed` step in the same frame: both apply. `high_score` compares the pre-increment `score`.
  - `rst` low mid-game: immediate return to reset values, including `high_score`.

## Timing
- `vsync` first sampled high at edge k → `update` high for the single cycle after edge k+3. Across consecutive vsync pulses, `update` is never high in two adjacent cycles.
- `timer`, `score`, `speed` and the crash latch register on the edge ending the `update` cycle. Downstream blocks therefore see the old values during `update`.
- Button change → `jump` change: 2 sync cycles + DEBOUNCE_CYCLES cycles + 1 cycle.
- `game_rst` asserts the cycle after `jump_rise`. `crash` is low and `playing` is high in that same cycle.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, ACCEL_FRAMES=3, HOLDOFF_FRAMES=2, SPEED_MAX=8, SPEED_INIT=6.

- Reset, then 65 vsync pulses with no button press → state IDLE, 65 single-cycle `update` pulses, `timer` = 5 (wrapped once), `score` = 0.
- Button glitch high for 3 cycles → `jump` stays 0. Button held 10 cycles → `jump` = 1, IDLE→PLAYING, `playing` = 1.
- PLAYING for 9 frames → `speed` goes 6→7→8 and stays 8; `score` = 3·6 + 3·7 + 3·8 = 63.
- `collision` pulse between `update` strobes → no crash. `collision` high across an `update` with `score` = 63 → `crash` = 1, `high_score` = 63, `jump` = 0, `timer` frozen.
- In OVER, press before 2 frames → no `game_rst`. Release, wait 2 frames, press → exactly one `game_rst` cycle; `score` = 0, `speed` = 6, `crash` = 0, `high_score` stays 63.
- Pull `rst` low mid-PLAYING, asynchronously between clock edges → all outputs return to reset values immediately, `high_score` = 0.
